// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the video
// character-fetch path (priority) and the Z80 CPU bus. The CPU is forced through
// after MAX_WAIT lost slots. The video fetch it displaces is reported as a miss
// and counted.
module vram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_miss,
    output logic [CNT_W-1:0]  miss_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_PEND   = 2'd1,
        C_ISSUED = 2'd2
    } cpu_state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    cpu_state_t state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;

    // Pipeline flags: stage 1 follows the address edge, stage 2 is the cycle
    // in which the RAM read data is on ram_rdata.
    logic cpu_wr_p1_reg, cpu_rd_p1_reg, vid_p1_reg, miss_p1_reg;
    logic cpu_rd_p2_reg, vid_p2_reg, miss_p2_reg;

    logic cpu_cand, force_cpu, cpu_grant, vid_grant, vid_drop, ack_rise;

    // Arbitration for this edge. The CPU cannot start another access while
    // its previous one is still in flight.
    always_comb begin
        cpu_cand  = cpu_req && (state_reg != C_ISSUED);
        force_cpu = cpu_cand && (wait_cnt_reg == MAX_WAIT_C);
        cpu_grant = cpu_cand && (force_cpu || !vid_req);
        vid_grant = vid_req && !force_cpu;
        vid_drop  = vid_req && force_cpu;
        ack_rise  = cpu_wr_p1_reg || cpu_rd_p2_reg;
    end

    // CPU FSM next state and lost-slot counter.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            C_IDLE: begin
                if (cpu_req) state_next = cpu_grant ? C_ISSUED : C_PEND;
            end
            C_PEND: begin
                if (!cpu_req)      state_next = C_IDLE;
                else if (cpu_grant) state_next = C_ISSUED;
            end
            C_ISSUED: begin
                if (ack_rise) state_next = C_IDLE;
            end
            default: state_next = C_IDLE;
        endcase
        if (cpu_grant || (state_reg == C_PEND && !cpu_req))
            wait_cnt_next = 4'd0;
        else if (cpu_cand && vid_grant)
            wait_cnt_next = wait_cnt_reg + 4'd1;
    end

    // FSM state, lost-slot counter and registered wait flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= C_IDLE;
            wait_cnt_reg <= 4'd0;
            cpu_wait     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            cpu_wait     <= (state_next == C_PEND);
        end
    end

    // Registered RAM port: the winner's address goes out on the grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (cpu_grant) begin
            ram_addr  <= cpu_addr;
            ram_we    <= cpu_we;
            ram_wdata <= cpu_wdata;
        end else if (vid_grant) begin
            ram_addr  <= vid_addr;
            ram_we    <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    // Access tracking pipeline; a reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_wr_p1_reg <= 1'b0;
            cpu_rd_p1_reg <= 1'b0;
            vid_p1_reg    <= 1'b0;
            miss_p1_reg   <= 1'b0;
            cpu_rd_p2_reg <= 1'b0;
            vid_p2_reg    <= 1'b0;
            miss_p2_reg   <= 1'b0;
        end else begin
            cpu_wr_p1_reg <= cpu_grant && cpu_we;
            cpu_rd_p1_reg <= cpu_grant && !cpu_we;
            vid_p1_reg    <= vid_grant;
            miss_p1_reg   <= vid_drop;
            cpu_rd_p2_reg <= cpu_rd_p1_reg;
            vid_p2_reg    <= vid_p1_reg;
            miss_p2_reg   <= miss_p1_reg;
        end
    end

    // Completion pulses, captured read data and the saturating miss counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_valid  <= 1'b0;
            vid_miss   <= 1'b0;
            vid_data   <= '0;
            miss_count <= '0;
        end else begin
            cpu_ack   <= ack_rise;
            vid_valid <= vid_p2_reg;
            vid_miss  <= miss_p2_reg;
            if (cpu_rd_p2_reg) cpu_rdata <= ram_rdata;
            if (vid_p2_reg)    vid_data  <= ram_rdata;
            if (miss_p2_reg && (miss_count != {CNT_W{1'b1}}))
                miss_count <= miss_count + 1'b1;
        end
    end

endmodule
